// File: rtl/msb_pkg.sv
// Shared definitions for the BRAM stream reader: BRAM read latency, default sizes
// and the ring-pointer increment used by both the read pointer and the skid FIFO.
package msb_pkg;

   localparam int unsigned BRAM_RD_LATENCY = 2;
   localparam int unsigned DEF_DATA_WIDTH  = 64;
   localparam int unsigned DEF_RAM_DEPTH   = 512;

   // Increment with wrap at an arbitrary depth (depth need not be a power of two).
   function automatic int unsigned ptr_wrap(input int unsigned ptr, input int unsigned depth);
      return (ptr == depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/base_vlat.sv
// One register stage with synchronous active-low reset and synchronous clear;
// chained to delay the read-valid strobe by the BRAM read latency.
module base_vlat #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_clear,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   always_ff @(posedge clk) begin
      if (!reset || i_clear) o_q <= '0;
      else                   o_q <= i_d;
   end

endmodule

// File: rtl/stream_skid_fifo.sv
// Small output FIFO that absorbs reads already in flight from the BRAM;
// write-enable in, valid/ready out, synchronous active-low reset plus flush.
module stream_skid_fifo import msb_pkg::*; #(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_flush,
   input  logic                  i_we,
   input  logic [DATA_WIDTH-1:0] i_wd,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [DATA_WIDTH-1:0] o_rd
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]         wp_q, rp_q;
   logic [CW-1:0]         cnt_q;
   logic                  pop;

   assign o_valid = (cnt_q != '0);
   assign pop     = o_valid && i_ready;
   assign o_rd    = o_valid ? mem[rp_q] : '0;

   // Storage is not reset; the pointers alone decide what is visible.
   always_ff @(posedge clk) begin
      if (i_we) mem[wp_q] <= i_wd;
   end

   always_ff @(posedge clk) begin
      if (!reset || i_flush) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (i_we) wp_q <= PW'(ptr_wrap(32'(wp_q), DEPTH));
         if (pop)  rp_q <= PW'(ptr_wrap(32'(rp_q), DEPTH));
         if (i_we && !pop)      cnt_q <= cnt_q + CW'(1);
         else if (!i_we && pop) cnt_q <= cnt_q - CW'(1);
      end
   end

endmodule

// File: rtl/bram_stream_reader.sv
// Read-side engine for one stream in the double-pumped BRAM: tracks committed entries,
// issues credit-limited reads and delivers data in order on a valid/ready handshake.
module bram_stream_reader import msb_pkg::*; #(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned RAM_DEPTH  = DEF_RAM_DEPTH,
   parameter int unsigned ADDR_WIDTH = $clog2(RAM_DEPTH),
   parameter int unsigned RD_LATENCY = BRAM_RD_LATENCY,
   parameter int unsigned SKID_DEPTH = 4
) (
   input  logic                  clk2x,
   input  logic                  reset,
   input  logic                  i_flush,
   input  logic                  i_push,
   output logic                  o_full,
   output logic [ADDR_WIDTH:0]   o_count,
   output logic                  o_re,
   output logic [ADDR_WIDTH-1:0] o_ra,
   input  logic [DATA_WIDTH-1:0] i_rd,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [DATA_WIDTH-1:0] o_data
);

   localparam int unsigned CW = $clog2(SKID_DEPTH + 1);
   localparam logic [ADDR_WIDTH:0] DEPTH_C    = (ADDR_WIDTH + 1)'(RAM_DEPTH);
   localparam logic [CW-1:0]       CREDIT_MAX = CW'(SKID_DEPTH);

   logic [ADDR_WIDTH:0]   count_q;
   logic [ADDR_WIDTH-1:0] rd_ptr_q;
   logic [CW-1:0]         credit_q;
   logic                  push_ok, re, pop;
   logic [RD_LATENCY:0]   vpipe;

   assign o_full  = (count_q == DEPTH_C);
   assign push_ok = i_push && !o_full;
   // A credit per skid slot guarantees every issued read has somewhere to land.
   assign re      = (count_q != '0) && (credit_q != '0) && !i_flush;
   assign pop     = o_valid && i_ready;

   assign o_re    = re;
   assign o_ra    = rd_ptr_q;
   assign o_count = count_q;

   always_ff @(posedge clk2x) begin
      if (!reset || i_flush) begin
         count_q  <= '0;
         rd_ptr_q <= '0;
         credit_q <= CREDIT_MAX;
      end else begin
         if (push_ok && !re)      count_q <= count_q + 1'b1;
         else if (!push_ok && re) count_q <= count_q - 1'b1;
         if (re) rd_ptr_q <= ADDR_WIDTH'(ptr_wrap(32'(rd_ptr_q), RAM_DEPTH));
         if (pop && !re)      credit_q <= credit_q + CW'(1);
         else if (!pop && re) credit_q <= credit_q - CW'(1);
      end
   end

   assign vpipe[0] = re;
   for (genvar i = 0; i < RD_LATENCY; i++) begin : g_vlat
      base_vlat #(.WIDTH(1)) u_vlat (
         .clk     (clk2x),
         .reset   (reset),
         .i_clear (i_flush),
         .i_d     (vpipe[i]),
         .o_q     (vpipe[i+1])
      );
   end

   stream_skid_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(SKID_DEPTH)) u_skid (
      .clk     (clk2x),
      .reset   (reset),
      .i_flush (i_flush),
      .i_we    (vpipe[RD_LATENCY]),
      .i_wd    (i_rd),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_rd    (o_data)
   );

   push_when_full : assert property (@(posedge clk2x) disable iff (!reset)
      !(i_push && o_full && !i_flush));

endmodule

// File: tb/tb_bram_stream_reader.sv
// Scoreboard bench for bram_stream_reader with a behavioural writer and 2-cycle BRAM.
module tb_bram_stream_reader;

   localparam int unsigned DW    = 64;
   localparam int unsigned DEPTH = 12;
   localparam int unsigned AW    = $clog2(DEPTH);

   logic          clk2x = 0, reset = 0, i_flush = 0, i_push = 0, i_ready = 0;
   logic          o_full, o_re, o_valid;
   logic [AW:0]   o_count;
   logic [AW-1:0] o_ra;
   logic [DW-1:0] i_rd, o_data, wdata = '0;

   always #5 clk2x = ~clk2x;

   bram_stream_reader #(.DATA_WIDTH(DW), .RAM_DEPTH(DEPTH)) dut (
      .clk2x(clk2x), .reset(reset), .i_flush(i_flush), .i_push(i_push),
      .o_full(o_full), .o_count(o_count), .o_re(o_re), .o_ra(o_ra), .i_rd(i_rd),
      .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data)
   );

   // Writer ring and read_first BRAM with two-cycle read latency.
   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] rd_s1 = '0, rd_s2 = '0;
   int unsigned   wr_ptr = 0;
   always @(posedge clk2x) begin
      if (o_re) rd_s1 <= mem[o_ra];
      rd_s2 <= rd_s1;
      if (!reset || i_flush) wr_ptr <= 0;
      else if (i_push && !o_full) begin
         mem[wr_ptr] <= wdata;
         wr_ptr <= (wr_ptr == DEPTH - 1) ? 0 : wr_ptr + 1;
      end
   end
   assign i_rd = rd_s2;

   int unsigned vectors = 0, miscompares = 0;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Monitor: scoreboard, read-address sequence, hold rule, run lengths.
   logic [DW-1:0] exp_q[$];
   int unsigned   exp_ra = 0, re_total = 0, re_run = 0, last_re_run = 0;
   int unsigned   pop_run = 0, last_pop_run = 0;
   logic          hold_pend = 0;
   logic [DW-1:0] hold_data = '0;

   always @(negedge clk2x) begin
      if (!reset || i_flush) begin
         exp_q.delete();
         exp_ra  = 0;
         re_run  = 0;
         pop_run = 0;
      end else begin
         if (i_push && !o_full) exp_q.push_back(wdata);
         if (hold_pend) begin
            check("hold_valid", o_valid, 1);
            check("hold_data", o_data, hold_data);
         end
         if (o_re) begin
            check("o_ra", o_ra, exp_ra);
            exp_ra = (exp_ra == DEPTH - 1) ? 0 : exp_ra + 1;
            re_total++;
            re_run++;
         end else if (re_run != 0) begin
            last_re_run = re_run;
            re_run = 0;
         end
         if (o_valid && i_ready) begin
            check("sb_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("o_data", o_data, exp_q.pop_front());
            pop_run++;
         end else if (pop_run != 0) begin
            last_pop_run = pop_run;
            pop_run = 0;
         end
      end
      hold_pend = reset && !i_flush && o_valid && !i_ready;
      hold_data = o_data;
   end

   task automatic step();
      @(posedge clk2x);
      #1;
   endtask

   task automatic push_g(input int unsigned n);
      int unsigned k = 0, guard = 0;
      while (k < n && guard < 1000) begin
         if (!o_full) begin
            i_push = 1;
            wdata  = {$urandom, $urandom};
            k++;
         end else i_push = 0;
         step();
         guard++;
      end
      i_push = 0;
      check("push_budget", k, n);
   endtask

   task automatic drain(input string tag);
      int unsigned n = 0;
      while ((exp_q.size() != 0 || o_valid) && n < 200) begin
         step();
         n++;
      end
      step();
      check({"drain_", tag}, exp_q.size(), 0);
   endtask

   task automatic do_flush();
      i_flush = 1;
      step();
      i_flush = 0;
   endtask

   int unsigned r0;
   logic [DW-1:0] v;

   initial begin
      // T1: reset held with a push pending
      i_push = 1;
      wdata  = 64'hDEAD_BEEF_0000_0001;
      for (int i = 0; i < 3; i++) begin
         step();
         check("rst_full", o_full, 0);
         check("rst_count", o_count, 0);
         check("rst_re", o_re, 0);
         check("rst_ra", o_ra, 0);
         check("rst_valid", o_valid, 0);
         check("rst_data", o_data, 0);
      end
      i_push = 0;
      reset  = 1;
      repeat (3) step();

      // T2: single push latency
      i_ready = 1;
      v = 64'h0123_4567_89AB_CDEF;
      i_push = 1; wdata = v;
      step();
      i_push = 0;
      check("t2_re", o_re, 1);
      check("t2_ra", o_ra, 0);
      step(); check("t2_valid_n2", o_valid, 0);
      step(); check("t2_valid_n3", o_valid, 0);
      step(); check("t2_valid_n4", o_valid, 1); check("t2_data", o_data, v);
      step(); check("t2_valid_n5", o_valid, 0);
      drain("t2");

      // T3: 8 back-to-back pushes from a fresh pointer
      do_flush();
      r0 = re_total;
      push_g(8);
      drain("t3");
      check("t3_reads", re_total - r0, 8);
      check("t3_re_run", last_re_run, 8);
      check("t3_pop_run", last_pop_run, 8);

      // T4: backpressure limits reads to the skid depth
      i_ready = 0;
      r0 = re_total;
      push_g(10);
      repeat (6) step();
      check("t4_reads", re_total - r0, 4);
      check("t4_re", o_re, 0);
      check("t4_count", o_count, 6);
      i_ready = 1;
      drain("t4");
      check("t4_pop_run", last_pop_run, 10);

      // T5: fill to full, then wrap twice
      do_flush();
      i_ready = 0;
      r0 = re_total;
      push_g(16);
      repeat (4) step();
      check("t5_full", o_full, 1);
      check("t5_count", o_count, DEPTH);
      i_ready = 1;
      push_g(2 * DEPTH + 2 - 16);
      drain("t5");
      check("t5_reads", re_total - r0, 2 * DEPTH + 2);
      check("t5_empty", o_full, 0);

      // T6: flush with data in the FIFO and a read in flight
      i_ready = 0;
      push_g(6);
      check("t6_valid_pre", o_valid, 1);
      do_flush();
      check("t6_valid", o_valid, 0);
      check("t6_count", o_count, 0);
      check("t6_re", o_re, 0);
      for (int i = 0; i < 5; i++) begin
         step();
         check("t6_no_stale", o_valid, 0);
      end
      r0 = re_total;
      push_g(6);
      repeat (6) step();
      check("t6_credit_reads", re_total - r0, 4);
      check("t6_count_after", o_count, 2);
      i_ready = 1;
      drain("t6");

      // T7: reset mid-burst
      push_g(3);
      step();
      reset = 0;
      step();
      reset = 1;
      check("t7_valid", o_valid, 0);
      check("t7_count", o_count, 0);
      for (int i = 0; i < 5; i++) begin
         step();
         check("t7_no_stale", o_valid, 0);
      end
      r0 = re_total;
      push_g(1);
      drain("t7");
      check("t7_reads", re_total - r0, 1);

      check("sb_final", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
